// File: rtl/auth_host_sequencer.sv
// auth_host_sequencer: sequences a USB Type-C Authentication exchange
// (GET_DIGESTS, GET_CERTIFICATE, CHALLENGE) against a responder.
//   clk, reset (async, active-low)
//   start, slot           : begin an exchange using certificate slot
//   busy, done, pass,     : status; done pulses at the end, pass/err_code
//   err_code                held until the next accepted start
//   resp_req_out, bmRequestType, bRequest, wLength, auth_msg_resp_out,
//   Ack_in                : AUTH_OUT/AUTH_IN request handshake
//   resp_req_in, auth_msg_resp_in, Ack_out_resp : response handshake
module auth_host_sequencer #(
    parameter int          MSG_LEN     = 32,
    parameter int          TIMEOUT_CYC = 1000,
    parameter int          MAX_RETRY   = 3,
    parameter logic [15:0] DIG_WLEN    = 16'd36,
    parameter logic [15:0] CERT_WLEN   = 16'd512,
    parameter logic [15:0] CHAL_WLEN   = 16'd168
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         slot,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_code,
    output logic               resp_req_out,
    output logic [7:0]         bmRequestType,
    output logic [7:0]         bRequest,
    output logic [15:0]        wLength,
    output logic [MSG_LEN-1:0] auth_msg_resp_out,
    input  logic               Ack_in,
    input  logic               resp_req_in,
    input  logic [MSG_LEN-1:0] auth_msg_resp_in,
    output logic               Ack_out_resp
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OUT   = 3'd1;
    localparam logic [2:0] S_IN    = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [1:0] PH_CHAL = 2'd2;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    logic [2:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [1:0]    slot_q, slot_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rsp_q, rsp_d;
    logic          pass_d;
    logic [2:0]    err_d;
    logic          waiting, progress, tmo_fire;
    logic [7:0]    exp_type;
    logic [15:0]   in_wlen;
    logic          unused_hi;

    assign unused_hi = ^auth_msg_resp_in[MSG_LEN-1:16];
    assign waiting   = state_q == S_OUT || state_q == S_IN || state_q == S_WAIT;
    // An Ack or response arriving on the timeout cycle takes priority.
    assign progress  = ((state_q == S_OUT || state_q == S_IN) && Ack_in) ||
                       (state_q == S_WAIT && resp_req_in);
    assign tmo_fire  = waiting && !progress && cnt_q == CW'(TIMEOUT_CYC - 1);
    assign exp_type  = 8'h01 + {6'b0, phase_q};
    assign in_wlen   = phase_d == 2'd0 ? DIG_WLEN : phase_d == 2'd1 ? CERT_WLEN : CHAL_WLEN;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        retry_d = retry_q;
        rsp_d   = rsp_q;
        pass_d  = pass;
        err_d   = err_code;
        case (state_q)
            S_IDLE: if (start) begin
                slot_d  = slot;
                phase_d = 2'd0;
                retry_d = '0;
                pass_d  = 1'b0;
                err_d   = 3'd0;
                state_d = S_OUT;
            end
            S_OUT:  if (Ack_in) state_d = S_IN;
            S_IN:   if (Ack_in) state_d = S_WAIT;
            S_WAIT: if (resp_req_in) begin
                rsp_d   = auth_msg_resp_in[15:0];
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_FIN;
                if (rsp_q[7:0] != 8'h01) err_d = 3'd4;
                else if (rsp_q[15:8] == 8'h7F) err_d = 3'd2;
                else if (rsp_q[15:8] != exp_type) err_d = 3'd3;
                else if (phase_q != PH_CHAL) begin
                    phase_d = phase_q + 2'd1;
                    retry_d = '0;
                    state_d = S_OUT;
                end else pass_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_fire) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = S_OUT;
            end else begin
                err_d   = 3'd1;
                state_d = S_FIN;
            end
        end
        // Restart the count whenever a wait state is (re)entered.
        cnt_d = (waiting && state_d == state_q && !tmo_fire) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            phase_q           <= '0;
            slot_q            <= '0;
            retry_q           <= '0;
            cnt_q             <= '0;
            rsp_q             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            err_code          <= 3'd0;
            resp_req_out      <= 1'b0;
            bmRequestType     <= 8'h00;
            bRequest          <= 8'h00;
            wLength           <= 16'h0000;
            auth_msg_resp_out <= '0;
            Ack_out_resp      <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            slot_q            <= slot_d;
            retry_q           <= retry_d;
            cnt_q             <= cnt_d;
            rsp_q             <= rsp_d;
            busy              <= state_d != S_IDLE;
            done              <= state_d == S_FIN;
            pass              <= pass_d;
            err_code          <= err_d;
            resp_req_out      <= state_d == S_OUT || state_d == S_IN;
            bmRequestType     <= state_d == S_OUT ? 8'h01 : state_d == S_IN ? 8'h81 : 8'h00;
            bRequest          <= state_d == S_OUT ? 8'h19 : state_d == S_IN ? 8'h18 : 8'h00;
            wLength           <= state_d == S_OUT ? 16'd4 : state_d == S_IN ? in_wlen : 16'd0;
            auth_msg_resp_out <= state_d == S_OUT ?
                MSG_LEN'({8'h00, 6'b0, slot_d, 8'h81 + {6'b0, phase_d}, 8'h01}) : '0;
            Ack_out_resp      <= state_d == S_CHECK;
        end
    end
endmodule

// File: tb/tb_auth_host_sequencer.sv
// tb_auth_host_sequencer: scoreboard bench for auth_host_sequencer
module tb_auth_host_sequencer;
    localparam int T = 20;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, stray = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic        busy, done, pass, resp_req_out, Ack_out_resp;
    logic [2:0]  err_code;
    logic [7:0]  bmRequestType, bRequest;
    logic [15:0] wLength;
    logic [31:0] auth_msg_resp_out;
    logic        Ack_in = 1'b0, rsp_v = 1'b0;
    logic [31:0] rsp_hdr = 32'h0;

    always #5 clk = ~clk;

    auth_host_sequencer #(.MSG_LEN(32), .TIMEOUT_CYC(T), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .start(start), .slot(slot),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .resp_req_out(resp_req_out), .bmRequestType(bmRequestType),
        .bRequest(bRequest), .wLength(wLength),
        .auth_msg_resp_out(auth_msg_resp_out), .Ack_in(Ack_in),
        .resp_req_in(rsp_v | stray), .auth_msg_resp_in(rsp_hdr),
        .Ack_out_resp(Ack_out_resp)
    );

    typedef struct {
        logic [7:0]  bm;
        logic [7:0]  br;
        logic [15:0] wl;
        logic [31:0] hdr;
        int          gap;
    } req_t;

    req_t        exp_req[$];
    logic [3:0]  exp_res[$];
    logic [32:0] rsp_tab[$];
    req_t        e_m;
    logic [3:0]  r_m;
    logic [32:0] rr;
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, last_hs = 0, wd_req = 0, wd_seen = 0;
    logic chk_zero = 1'b0, chk_idle = 1'b0, chk_empty = 1'b0, hs_r = 1'b0, ack_r = 1'b0;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (wd_req != wd_seen) begin
            wd_seen = wd_req;
            total++;
            bad++;
            $display("FAIL watchdog: got no done expected done within budget");
        end
        if (chk_zero)
            cmp("reset_outputs", {busy, done, pass, err_code, resp_req_out, bmRequestType,
                bRequest, wLength, auth_msg_resp_out, Ack_out_resp}, '0);
        if (chk_idle) cmp("stray_ignored", {busy, Ack_out_resp}, 0);
        if (chk_empty) cmp("queues_drained", exp_req.size() + exp_res.size() + rsp_tab.size(), 0);
        if (resp_req_out && Ack_in) begin
            if (exp_req.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_request: got bm=%0h type=%0h expected none",
                         bmRequestType, auth_msg_resp_out[15:8]);
            end else begin
                e_m = exp_req.pop_front();
                cmp("request", {bmRequestType, bRequest, wLength, e_m.bm == 8'h01 ? auth_msg_resp_out : 32'h0},
                    {e_m.bm, e_m.br, e_m.wl, e_m.bm == 8'h01 ? e_m.hdr : 32'h0});
                if (e_m.gap >= 0) cmp("retry_gap", cyc - last_hs, e_m.gap);
            end
            last_hs = cyc;
        end
        if (done) begin
            done_cnt++;
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got pass=%0b err=%0d expected no done", pass, err_code);
            end else begin
                r_m = exp_res.pop_front();
                cmp("result", {pass, err_code}, r_m);
            end
        end
    end

    // Responder: acks every request at once, answers AUTH_IN from rsp_tab.
    always begin
        @(negedge clk);
        hs_r  = resp_req_out && Ack_in && bmRequestType == 8'h81;
        ack_r = Ack_out_resp;
        @(posedge clk);
        #2;
        if (!reset) begin
            rsp_v = 1'b0;
            hs_r  = 1'b0;
        end
        if (ack_r) rsp_v = 1'b0;
        if (hs_r && rsp_tab.size() != 0) begin
            rr = rsp_tab.pop_front();
            if (!rr[32]) begin
                rsp_v   = 1'b1;
                rsp_hdr = rr[31:0];
            end
        end
        Ack_in = resp_req_out;
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_ph(input int ph, input logic [1:0] s, input int gap);
        logic [7:0] t;
        t = 8'h81 + 8'(ph);
        exp_req.push_back('{8'h01, 8'h19, 16'd4, {8'h00, 6'b0, s, t, 8'h01}, gap});
        exp_req.push_back('{8'h81, 8'h18, ph == 0 ? 16'd36 : ph == 1 ? 16'd512 : 16'd168, 32'h0, -1});
    endtask

    task automatic push_rsp(input logic drop, input logic [7:0] ver, input logic [7:0] typ);
        rsp_tab.push_back({drop, 16'h0000, typ, ver});
    endtask

    task automatic wait_done();
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = done_cnt != d0;
        end
        if (!seen) wd_req++;
    endtask

    task automatic run(input logic [1:0] s);
        slot = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        chk_zero = 1'b1;
        tick();
        tick();
        chk_zero = 1'b0;
        reset = 1'b1;
        tick();
        // nominal
        push_ph(0, 2, -1); push_ph(1, 2, -1); push_ph(2, 2, -1);
        push_rsp(0, 8'h01, 8'h01); push_rsp(0, 8'h01, 8'h02); push_rsp(0, 8'h01, 8'h03);
        exp_res.push_back({1'b1, 3'd0});
        run(2);
        // timeout then recovery
        push_ph(0, 1, -1); push_ph(0, 1, T + 1); push_ph(1, 1, -1); push_ph(2, 1, -1);
        push_rsp(1, 8'h01, 8'h01); push_rsp(0, 8'h01, 8'h01);
        push_rsp(0, 8'h01, 8'h02); push_rsp(0, 8'h01, 8'h03);
        exp_res.push_back({1'b1, 3'd0});
        run(1);
        // retries exhausted
        push_ph(0, 0, -1);
        for (int i = 0; i < 3; i++) push_ph(0, 0, T + 1);
        for (int i = 0; i < 4; i++) push_rsp(1, 8'h01, 8'h01);
        exp_res.push_back({1'b0, 3'd1});
        run(0);
        // ERROR response in CERTIFICATE
        push_ph(0, 1, -1); push_ph(1, 1, -1);
        push_rsp(0, 8'h01, 8'h01); push_rsp(0, 8'h01, 8'h7F);
        exp_res.push_back({1'b0, 3'd2});
        run(1);
        // wrong type in CHALLENGE
        push_ph(0, 2, -1); push_ph(1, 2, -1); push_ph(2, 2, -1);
        push_rsp(0, 8'h01, 8'h01); push_rsp(0, 8'h01, 8'h02); push_rsp(0, 8'h01, 8'h02);
        exp_res.push_back({1'b0, 3'd3});
        run(2);
        // version mismatch
        push_ph(0, 0, -1);
        push_rsp(0, 8'h02, 8'h01);
        exp_res.push_back({1'b0, 3'd4});
        run(0);
        // reset while waiting for a response
        push_ph(0, 0, -1);
        push_rsp(1, 8'h01, 8'h01);
        slot = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        chk_zero = 1'b1;
        tick();
        chk_zero = 1'b0;
        reset = 1'b1;
        tick();
        // new exchange succeeds; start and slot changes while busy are ignored
        push_ph(0, 3, -1); push_ph(1, 3, -1); push_ph(2, 3, -1);
        push_rsp(0, 8'h01, 8'h01); push_rsp(0, 8'h01, 8'h02); push_rsp(0, 8'h01, 8'h03);
        exp_res.push_back({1'b1, 3'd0});
        slot = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        slot = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick();
        // stray response while idle
        chk_idle = 1'b1;
        stray = 1'b1;
        repeat (5) tick();
        stray = 1'b0;
        repeat (2) tick();
        chk_idle = 1'b0;
        chk_empty = 1'b1;
        tick();
        chk_empty = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
